free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
// - Circular FIFO of free integer physical registers, directly upstream of rat.
// - Each cycle it grants up to RENAME_WIDTH new PRF indices to rename slots that write rd.
// - It takes back up to RENAME_WIDTH stale PRF indices released at retire.
// - It snapshots and restores its head pointer per checkpoint so branch recovery returns speculatively allocated registers.
// PARAMETERS
// - PRF_SIZE     64  physical integer registers; power of 2
// - ARF_SIZE     32  architectural registers; PRF 0..ARF_SIZE-1 are mapped at reset, never in the list initially
// - WIDTH         4  rename/retire width (= `RENAME_WIDTH)
// - CP_SIZE       4  checkpoint slots (= `RAT_CP_SIZE)
// - derived: IW = clog2(PRF_SIZE); DEPTH = PRF_SIZE; PW = clog2(DEPTH)+1 (pointer with wrap bit)
// PORTS
// - clock          in   1          clock, rising edge
// - reset          in   1          synchronous, active-high
// - alloc_req      in   WIDTH      slot i needs a new rd PRF
// - alloc_grant    out  1          comb: all requested slots served this cycle
// - alloc_prf      out  WIDTH*IW   comb: PRF index per slot; 0 where alloc_req[i]=0
// - free_valid     in   WIDTH      slot i releases free_prf[i]
// - free_prf       in   WIDTH*IW   released PRF indices
// - cp_take        in   1          snapshot head into cp_idx
// - cp_idx         in   clog2(CP_SIZE)  checkpoint slot written by cp_take
// - recover        in   1          restore head from recover_idx
// - recover_idx    in   clog2(CP_SIZE)  checkpoint slot to restore
// - free_count     out  clog2(PRF_SIZE)+1  registered: entries currently free
// - dup_err        out  1          registered error flag; see CONFIGURATION
// BEHAVIOUR
// - Storage: DEPTH x IW array, head/tail PW-bit pointers, count = tail - head (PW bits, modular).
// - Reset: entry k = ARF_SIZE+k for k < PRF_SIZE-ARF_SIZE; head=0; tail=PRF_SIZE-ARF_SIZE.
//   Also free_count=PRF_SIZE-ARF_SIZE, all checkpoint slots=0, dup_err=0. Other array entries are don't-care.
// - Allocation (comb):
//   - n = popcount(alloc_req); alloc_grant = (n <= count) & ~recover.
//   - n=0 gives alloc_grant=1.
//   - alloc_prf[i] = array[head + popcount(alloc_req[i-1:0])], compacted in slot order.
//   - All-or-nothing: no partial grant. rat stalls the group while alloc_grant=0.
// - Head update (edge):
//   - recover=1: head <= cp[recover_idx]; allocation suppressed.
//   - else if alloc_grant: head <= head + n.
// - Free (edge):
//   - m = popcount(free_valid); free_prf written compacted at tail, tail+1, ... in slot order.
//   - tail <= tail + m. Applied on recover cycles too.
//   - Overflow (count + m > PRF_SIZE) is illegal upstream; simulation assertion only.
// - Visibility: a PRF freed in cycle t is allocatable from cycle t+1, never in cycle t (no bypass).
// - Checkpoint:
//   - cp_take=1: cp[cp_idx] <= head value after this cycle's allocation (head+n if granted, else head).
//   - A younger branch in the same group thus excludes its own group's allocations from recovery.
//   - cp_take together with recover: recover wins; the snapshot is dropped.
// - free_count <= tail_next - head_next, registered; it reflects the edge just taken.
// - Wrap-around: pointers roll over modulo 2*DEPTH; the array index is ptr[PW-2:0].
// - Empty: count=0 and any alloc_req set gives alloc_grant=0 and alloc_prf don't-care.
// - Full (count=PRF_SIZE) occurs only transiently; allocation is still legal.
// - Reset mid-operation restores reset state next edge regardless of other inputs.
// CONFIGURATION
// - FREE_LIST_DUP_CHECK_EN defined:
//   - Keep a PRF_SIZE-bit free_map, set for the initial free set at reset.
//   - Freeing an index already marked free, or an index < 1 (x0 physical), drops that write.
//   - Dropped writes do not advance tail and set sticky dup_err until reset.
//   - Allocation clears the granted bits; recover re-sets bits of entries between restored head and old head.
// - FREE_LIST_DUP_CHECK_EN undefined: no free_map; every free is accepted; dup_err tied 0.
// TESTING
// - reset; alloc_req=4'b1111 -> alloc_grant=1, alloc_prf={35,34,33,32}; next cycle free_count=28.
// - alloc_req=4'b1010 from reset -> alloc_prf[1]=32, alloc_prf[3]=33, others 0; head=2.
// - Drain to count=2, alloc_req=4'b0111 -> alloc_grant=0; head and free_count unchanged.
// - Same cycle alloc 4 and free {5,6} at count=4 -> grant; free_count=2; 5 and 6 returned only from the following cycle.
// - cp_take cp_idx=1 with 2 allocs (head 0->2); then 3 allocs; recover recover_idx=1 -> head=2, free_count+=3, next alloc returns 34.
// - Loop 200 cycles of alloc 4/free 4 -> pointer wrap; indices never duplicated.
//   - With FREE_LIST_DUP_CHECK_EN: free 40 twice -> second dropped, dup_err=1.

Source files
------------

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list -- circular FIFO of free integer physical registers (PRF indices)
//
// Sits directly upstream of the register alias table. Each cycle it grants up
// to WIDTH fresh PRF indices to the rename slots that write rd (all or
// nothing), accepts up to WIDTH stale indices released at retire, and keeps
// one head-pointer snapshot per checkpoint slot so branch recovery hands
// speculatively allocated registers back to the list.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   alloc_req    in   [WIDTH]      slot i needs a new rd PRF
//   alloc_grant  out  1            comb: every requesting slot is served
//   alloc_prf    out  [WIDTH*IW]   comb: PRF index per slot, 0 when not requested
//   free_valid   in   [WIDTH]      slot i releases free_prf[i]
//   free_prf     in   [WIDTH*IW]   released PRF indices
//   cp_take      in   1            snapshot post-allocation head into cp_idx
//   cp_idx       in   [CW]         checkpoint slot written by cp_take
//   recover      in   1            restore head from recover_idx
//   recover_idx  in   [CW]         checkpoint slot to restore
//   free_count   out  [IW+1]       registered number of free entries
//   dup_err      out  1            registered sticky duplicate-free flag
//
// Build option
//   FREE_LIST_DUP_CHECK_EN  when defined, a free_map tracks which indices sit
//                           in the list; releasing an index already free (or
//                           index 0) is dropped and sets dup_err until reset.
//                           When undefined every release is accepted and
//                           dup_err is tied low.
// ---------------------------------------------------------------------------

// Watches the release path for overflow, which upstream must never cause.
module free_list_checker #(
    parameter int PW       = 7,
    parameter int PRF_SIZE = 64
) (
    input logic          clock,
    input logic          reset,
    input logic [PW-1:0] count,
    input logic [PW-1:0] incoming
);
    localparam logic [PW:0] LIMIT = (PW+1)'(PRF_SIZE);

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        (({1'b0, count} + {1'b0, incoming}) <= LIMIT)
    );
endmodule

module free_list #(
    parameter int PRF_SIZE = 64,
    parameter int ARF_SIZE = 32,
    parameter int WIDTH    = 4,
    parameter int CP_SIZE  = 4,
    localparam int IW      = $clog2(PRF_SIZE),
    localparam int DEPTH   = PRF_SIZE,
    localparam int PW      = $clog2(DEPTH) + 1,
    localparam int CW      = $clog2(CP_SIZE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    alloc_req,
    output logic                alloc_grant,
    output logic [WIDTH*IW-1:0] alloc_prf,
    input  logic [WIDTH-1:0]    free_valid,
    input  logic [WIDTH*IW-1:0] free_prf,
    input  logic                cp_take,
    input  logic [CW-1:0]       cp_idx,
    input  logic                recover,
    input  logic [CW-1:0]       recover_idx,
    output logic [IW:0]         free_count,
    output logic                dup_err
);
    localparam int            INIT_FREE = PRF_SIZE - ARF_SIZE;
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] bits);
        logic [PW-1:0] total;
        total = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            total = total + {{(PW-1){1'b0}}, bits[i]};
        end
        return total;
    endfunction

    logic [IW-1:0]       mem_r [DEPTH];
    logic [PW-1:0]       head_r;
    logic [PW-1:0]       tail_r;
    logic [PW-1:0]       cp_r [CP_SIZE];
    logic [PW-1:0]       free_count_r;

    logic [PW-1:0]       count_s;
    logic [PW-1:0]       n_s;
    logic [PW-1:0]       m_s;
    logic [PW-1:0]       head_next_s;
    logic [PW-1:0]       tail_next_s;
    logic                alloc_grant_s;
    logic [WIDTH*IW-1:0] alloc_prf_s;
    logic [WIDTH-1:0]    accept_s;
    logic [IW-1:0]       wr_data_s [WIDTH];
    logic [PW-2:0]       wr_addr_s [WIDTH];

`ifdef FREE_LIST_DUP_CHECK_EN
    localparam logic [PRF_SIZE-1:0] INIT_MAP = {PRF_SIZE{1'b1}} << ARF_SIZE;

    logic [PRF_SIZE-1:0] free_map_r;
    logic [PRF_SIZE-1:0] free_map_seen_s;
    logic [PRF_SIZE-1:0] free_map_next_s;
    logic                dup_s;
    logic                dup_err_r;
`endif

    // Grant decision and slot-ordered, compacted read-out from the head window
    always_comb begin
        logic [PW-1:0] offset_v;
        logic [PW-1:0] rd_ptr_v;
        count_s       = tail_r - head_r;
        n_s           = popcount(alloc_req);
        alloc_grant_s = (n_s <= count_s) && !recover;
        alloc_prf_s   = {(WIDTH*IW){1'b0}};
        offset_v      = {PW{1'b0}};
        rd_ptr_v      = head_r;
        for (int i = 0; i < WIDTH; i++) begin
            rd_ptr_v = head_r + offset_v;
            if (alloc_req[i]) begin
                alloc_prf_s[i*IW +: IW] = mem_r[rd_ptr_v[PW-2:0]];
                offset_v                = offset_v + PTR_ONE;
            end else begin
                alloc_prf_s[i*IW +: IW] = {IW{1'b0}};
            end
        end
    end

    // Next head: recovery overrides allocation
    always_comb begin
        if (recover) begin
            head_next_s = cp_r[recover_idx];
        end else if (alloc_grant_s) begin
            head_next_s = head_r + n_s;
        end else begin
            head_next_s = head_r;
        end
    end

    // Filter releases and compact the accepted ones onto tail, tail+1, ...
    always_comb begin
        logic [PW-1:0] wr_ptr_v;
        logic [IW-1:0] idx_v;
        accept_s = {WIDTH{1'b0}};
        wr_ptr_v = tail_r;
`ifdef FREE_LIST_DUP_CHECK_EN
        dup_s           = 1'b0;
        free_map_seen_s = free_map_r;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            idx_v        = free_prf[i*IW +: IW];
            wr_data_s[i] = idx_v;
            wr_addr_s[i] = wr_ptr_v[PW-2:0];
`ifdef FREE_LIST_DUP_CHECK_EN
            // Earlier slots of the same group count as already free.
            if (free_valid[i] && (idx_v != {IW{1'b0}}) && !free_map_seen_s[idx_v]) begin
                accept_s[i]            = 1'b1;
                free_map_seen_s[idx_v] = 1'b1;
            end else begin
                dup_s = dup_s | free_valid[i];
            end
`else
            accept_s[i] = free_valid[i];
`endif
            if (accept_s[i]) begin
                wr_ptr_v = wr_ptr_v + PTR_ONE;
            end else begin
                wr_ptr_v = wr_ptr_v;
            end
        end
        m_s         = popcount(accept_s);
        tail_next_s = tail_r + m_s;
    end

`ifdef FREE_LIST_DUP_CHECK_EN
    // Free-map upkeep: granted entries leave, recovered window comes back
    always_comb begin
        logic [PW-1:0] span_v;
        logic [PW-1:0] ptr_v;
        free_map_next_s = free_map_seen_s;
        span_v          = head_r - head_next_s;
        ptr_v           = head_r;
        for (int k = 0; k < WIDTH; k++) begin
            ptr_v = head_r + PW'(k);
            if (alloc_grant_s && (PW'(k) < n_s)) begin
                free_map_next_s[mem_r[ptr_v[PW-2:0]]] = 1'b0;
            end else begin
                free_map_next_s = free_map_next_s;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            ptr_v = head_next_s + PW'(k);
            if (recover && (PW'(k) < span_v)) begin
                free_map_next_s[mem_r[ptr_v[PW-2:0]]] = 1'b1;
            end else begin
                free_map_next_s = free_map_next_s;
            end
        end
    end

    // Free-map and sticky duplicate flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            free_map_r <= INIT_MAP;
            dup_err_r  <= 1'b0;
        end else begin
            free_map_r <= free_map_next_s;
            dup_err_r  <= dup_err_r | dup_s;
        end
    end

    assign dup_err = dup_err_r;
`else
    assign dup_err = 1'b0;
`endif

    // Pointers, storage, checkpoints and registered occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r       <= {PW{1'b0}};
            tail_r       <= PW'(INIT_FREE);
            free_count_r <= PW'(INIT_FREE);
            for (int k = 0; k < INIT_FREE; k++) begin
                mem_r[k] <= IW'(ARF_SIZE + k);
            end
            for (int c = 0; c < CP_SIZE; c++) begin
                cp_r[c] <= {PW{1'b0}};
            end
        end else begin
            head_r       <= head_next_s;
            tail_r       <= tail_next_s;
            free_count_r <= tail_next_s - head_next_s;
            for (int i = 0; i < WIDTH; i++) begin
                if (accept_s[i]) begin
                    mem_r[wr_addr_s[i]] <= wr_data_s[i];
                end
            end
            // A snapshot taken alongside a recovery is dropped.
            if (cp_take && !recover) begin
                cp_r[cp_idx] <= head_next_s;
            end
        end
    end

    assign alloc_grant = alloc_grant_s;
    assign alloc_prf   = alloc_prf_s;
    assign free_count  = free_count_r;

    free_list_checker #(.PW(PW), .PRF_SIZE(PRF_SIZE)) u_checker (
        .clock    (clock),
        .reset    (reset),
        .count    (count_s),
        .incoming (m_s)
    );
endmodule

// File: tb/tb_free_list.sv
// Randomised and directed bench for free_list. The reference model is an
// unbounded log of every index ever pushed plus an absolute head position;
// checkpoints store absolute positions, so no wrap arithmetic is involved.
module tb_free_list;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  alloc_req;
    logic        alloc_grant;
    logic [23:0] alloc_prf;
    logic [3:0]  free_valid;
    logic [23:0] free_prf;
    logic        cp_take;
    logic [1:0]  cp_idx;
    logic        recover;
    logic [1:0]  recover_idx;
    logic [6:0]  free_count;
    logic        dup_err;

    always #5 clock = ~clock;

    free_list dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .alloc_prf   (alloc_prf),
        .free_valid  (free_valid),
        .free_prf    (free_prf),
        .cp_take     (cp_take),
        .cp_idx      (cp_idx),
        .recover     (recover),
        .recover_idx (recover_idx),
        .free_count  (free_count),
        .dup_err     (dup_err)
    );

    typedef struct { int idx; int pos; } own_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   log_q[$];
    int   m_head;
    int   m_cp[4];
    bit   m_free[64];
    bit   m_dup;
    own_t owned[$];
    int   last_prf[4];
    int   cp_rot;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        log_q.delete();
        owned.delete();
        for (int k = 0; k < 32; k++) log_q.push_back(32 + k);
        for (int k = 1; k < 32; k++) owned.push_back('{idx: k, pos: -1});
        for (int k = 0; k < 64; k++) m_free[k] = (k >= 32);
        for (int c = 0; c < 4; c++) m_cp[c] = 0;
        m_head = 0;
        m_dup  = 1'b0;
        cp_rot = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; alloc_req = 4'd0; free_valid = 4'd0; free_prf = 24'd0;
        cp_take = 1'b0; cp_idx = 2'd0; recover = 1'b0; recover_idx = 2'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_count", free_count, 32);
        check_eq("rst_dup", dup_err, 0);
    endtask

    task automatic step(input logic [3:0] req, input logic [3:0] fv, input logic [23:0] fp,
                        input logic cpt, input logic [1:0] cpi, input logic rec, input logic [1:0] ri);
        int cnt, n, pre, old_head, idx, found;
        bit grant;
        @(negedge clock);
        alloc_req = req; free_valid = fv; free_prf = fp;
        cp_take = cpt; cp_idx = cpi; recover = rec; recover_idx = ri;
        #1;
        cnt   = log_q.size() - m_head;
        n     = $countones(req);
        grant = (n <= cnt) && !rec;
        check_eq("grant", alloc_grant, grant);
        pre = 0;
        old_head = m_head;
        for (int i = 0; i < 4; i++) begin
            last_prf[i] = int'(alloc_prf[i*6 +: 6]);
            if (!req[i]) begin
                check_eq("prf_idle", alloc_prf[i*6 +: 6], 0);
            end else begin
                if (grant) begin
                    check_eq("prf", alloc_prf[i*6 +: 6], log_q[old_head + pre]);
                    found = 0;
                    foreach (owned[j]) if (owned[j].idx == log_q[old_head + pre]) found = 1;
                    check_eq("uniq", found, 0);
                    owned.push_back('{idx: log_q[old_head + pre], pos: old_head + pre});
                end
                pre++;
            end
        end
        if (rec) m_head = m_cp[ri];
        else if (grant) m_head = m_head + n;
        if (cpt && !rec) m_cp[cpi] = m_head;
        if (rec) begin
            for (int j = owned.size() - 1; j >= 0; j--) if (owned[j].pos >= m_head) owned.delete(j);
        end
`ifdef FREE_LIST_DUP_CHECK_EN
        if (grant) for (int p = old_head; p < old_head + n; p++) m_free[log_q[p]] = 1'b0;
        if (rec) for (int p = m_head; p < old_head; p++) m_free[log_q[p]] = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin
            if (fv[i]) begin
                idx = int'(fp[i*6 +: 6]);
                for (int j = owned.size() - 1; j >= 0; j--) if (owned[j].idx == idx) owned.delete(j);
`ifdef FREE_LIST_DUP_CHECK_EN
                if (idx == 0 || m_free[idx]) m_dup = 1'b1;
                else begin
                    log_q.push_back(idx);
                    m_free[idx] = 1'b1;
                end
`else
                log_q.push_back(idx);
`endif
            end
        end
        @(posedge clock);
        #1;
        check_eq("free_count", free_count, log_q.size() - m_head);
        check_eq("dup_err", dup_err, m_dup);
    endtask

    // One randomised cycle; releases only indices no live checkpoint can reclaim.
    task automatic rand_cycle(input bit burst);
        int mincp, pick;
        int safe[$];
        logic [3:0]  req, fv;
        logic [23:0] fp;
        logic        cpt, rec;
        logic [1:0]  cpi, ri;
        mincp = m_cp[0];
        for (int c = 1; c < 4; c++) if (m_cp[c] < mincp) mincp = m_cp[c];
        foreach (owned[j]) if (owned[j].pos < mincp) safe.push_back(owned[j].idx);
        req = burst ? 4'hF : 4'($urandom_range(0, 15));
        fv = 4'd0;
        fp = 24'd0;
        for (int i = 0; i < 4; i++) begin
            if ((burst || $urandom_range(0, 1) == 1) && safe.size() > 0) begin
                pick = $urandom_range(0, safe.size() - 1);
                fv[i] = 1'b1;
                fp[i*6 +: 6] = 6'(safe[pick]);
                safe.delete(pick);
            end
        end
        cpt = burst || ($urandom_range(0, 2) == 0);
        cpi = 2'(cp_rot);
        if (cpt) cp_rot++;
        ri  = 2'($urandom_range(0, 3));
        rec = !burst && ($urandom_range(0, 19) == 0) && (m_cp[ri] <= m_head);
        step(req, fv, fp, cpt, cpi, rec, ri);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Full-width allocation straight out of reset
        do_reset();
        step(4'b1111, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) check_eq("t1_prf", last_prf[i], 32 + i);
        check_eq("t1_count", free_count, 28);

        // Sparse request is compacted in slot order
        do_reset();
        step(4'b1010, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t2_prf0", last_prf[0], 0);
        check_eq("t2_prf1", last_prf[1], 32);
        check_eq("t2_prf2", last_prf[2], 0);
        check_eq("t2_prf3", last_prf[3], 33);
        check_eq("t2_count", free_count, 30);

        // Insufficient entries: no partial grant
        do_reset();
        for (int i = 0; i < 7; i++) step(4'b1111, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(4'b0011, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(4'b0111, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t3_grant", last_prf[3], 0);
        check_eq("t3_count", free_count, 2);

        // Allocate the last four while freeing 5 and 6; they appear next cycle
        do_reset();
        for (int i = 0; i < 7; i++) step(4'b1111, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(4'b1111, 4'b0011, {6'd0, 6'd0, 6'd6, 6'd5}, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t4_count", free_count, 2);
        step(4'b0011, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t4_prf0", last_prf[0], 5);
        check_eq("t4_prf1", last_prf[1], 6);

        // Checkpoint, speculative allocation, recovery; snapshot on recover is dropped
        do_reset();
        step(4'b0011, 4'd0, 24'd0, 1'b1, 2'd1, 1'b0, 2'd0);
        step(4'b0111, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t5_spec", free_count, 27);
        step(4'b0000, 4'd0, 24'd0, 1'b1, 2'd2, 1'b1, 2'd1);
        check_eq("t5_recover", free_count, 30);
        step(4'b0001, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t5_prf", last_prf[0], 34);
        step(4'b0000, 4'd0, 24'd0, 1'b0, 2'd0, 1'b1, 2'd2);
        check_eq("t5_cp2", free_count, 32);
        step(4'b0001, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("t5_prf2", last_prf[0], 32);

`ifdef FREE_LIST_DUP_CHECK_EN
        // Double release of 40 is dropped and flagged
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b1111, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(4'b0000, 4'b0001, {18'd0, 6'd40}, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("dup_first", dup_err, 0);
        step(4'b0000, 4'b0001, {18'd0, 6'd40}, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("dup_second", dup_err, 1);
        check_eq("dup_count", free_count, 21);
`endif

        // Sustained alloc-4/free-4 across many pointer wraps, then mixed traffic
        do_reset();
        for (int cyc = 0; cyc < 200; cyc++) rand_cycle(1'b1);
        for (int cyc = 0; cyc < 400; cyc++) rand_cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
